pred_error_acc: RTL and testbench

Downstream stage of the linear-regression predictor (price = 10 000 + 5 000 × size). It consumes each prediction on the predictor's ready pulse and pairs it with the ground-truth price label. Over a batch it accumulates absolute error, then computes the mean absolute error (MAE) with a sequential divider. The result scores the regression model during training and evaluation.

---
 rtl/pred_error_acc_pkg.sv | 12 +
 rtl/pred_error_acc_if.sv | 16 +
 rtl/pred_error_acc_seq_divider.sv | 64 ++++++
 rtl/pred_error_acc.sv | 101 ++++++++++
 tb/tb_pred_error_acc.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pred_error_acc_pkg.sv
// pred_error_acc_pkg: shared FSM type, default widths and the absolute-difference helper
//    for the prediction-error accumulator and its divider.
package pred_pkg;
   typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;
   localparam int PW_DEF = 32;
   localparam int CW_DEF = 8;
   // abs_diff works on the widest supported operand; callers zero-extend and truncate back
   localparam int MAXW = 64;
   function automatic logic [MAXW-1:0] abs_diff(input logic [MAXW-1:0] a, input logic [MAXW-1:0] b);
      return (a >= b) ? a - b : b - a;
   endfunction
endpackage

// File: rtl/pred_error_acc_if.sv
// pred_error_acc_if: prediction sample bus from the predictor to the error accumulator.
//    pred_valid : sample strobe (predictor ready pulse)
//    predict    : unsigned prediction
//    target     : unsigned ground-truth label, qualified by pred_valid
//    modports   : master drives the bus, slave consumes it
interface pred_error_acc_if
   import pred_pkg::*;
#(
   parameter int PW = PW_DEF
);
   logic          pred_valid;
   logic [PW-1:0] predict;
   logic [PW-1:0] target;
   modport master(output pred_valid, predict, target);
   modport slave(input pred_valid, predict, target);
endinterface

// File: rtl/pred_error_acc_seq_divider.sv
// seq_divider: restoring shift-subtract unsigned divider, one quotient bit per cycle.
//    clk, r0  : clock, asynchronous active-low reset
//    clear    : synchronous abort, drops any division in flight
//    start    : one-cycle request; operands are sampled on this edge
//    dividend : DW-bit unsigned dividend
//    divisor  : VW-bit unsigned divisor (must be non-zero)
//    quotient : low QW bits of the quotient, valid while done is high
//    busy     : division in progress
//    done     : one-cycle pulse DW cycles after start
module seq_divider #(
   parameter int DW = 40,
   parameter int VW = 8,
   parameter int QW = 32
) (
   input  logic          clk,
   input  logic          r0,
   input  logic          clear,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic [QW-1:0] quotient,
   output logic          busy,
   output logic          done
);
   localparam int NW = $clog2(DW + 1);
   logic [VW-1:0] rem, dvs, r_in, d_in;
   logic [DW-1:0] quo, q_in;
   logic [VW:0]   sh;
   logic          ge;
   logic [NW-1:0] cnt;
   // the start edge already performs the first iteration on the raw operands,
   // so DW edges from start to the final bit
   assign r_in = start ? '0 : rem;
   assign q_in = start ? dividend : quo;
   assign d_in = start ? divisor : dvs;
   assign sh = {r_in, q_in[DW-1]};
   assign ge = sh >= {1'b0, d_in};
   assign quotient = quo[QW-1:0];
   always_ff @(posedge clk or negedge r0)
      if (!r0) begin
         rem <= '0;
         dvs <= '0;
         quo <= '0;
         cnt <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else if (clear) begin
         rem <= '0;
         quo <= '0;
         cnt <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start || busy) begin
            rem <= ge ? VW'(sh - {1'b0, d_in}) : sh[VW-1:0];
            quo <= {q_in[DW-2:0], ge};
            dvs <= d_in;
            cnt <= start ? NW'(1) : cnt + NW'(1);
            busy <= start || cnt != NW'(DW - 1);
            done <= !start && cnt == NW'(DW - 1);
         end
      end
endmodule

// File: rtl/pred_error_acc.sv
// pred_error_acc: accumulates |predict - target| over a batch and reports the mean absolute error.
//    clk, r0     : clock, asynchronous active-low reset
//    batch_start : one-cycle pulse; latches batch_size, clears the batch, aborts any batch in flight
//    batch_size  : samples per batch (0 is treated as 1)
//    pin         : sample bus (pred_valid, predict, target), slave side
//    busy        : batch in progress
//    count       : samples accepted in the current batch
//    sum_err     : running sum of absolute errors
//    mae         : floor(sum_err / batch size), held until the next completed batch
//    mae_valid   : one-cycle pulse when mae updates
//    max_err     : largest per-sample error of the batch (only with MAX_ERR_EN defined)
//    Build option: define MAX_ERR_EN to add the max_err output.
module pred_error_acc
   import pred_pkg::*;
#(
   parameter int PW = PW_DEF,
   parameter int CW = CW_DEF,
   parameter int AW = PW + CW
) (
   input  logic            clk,
   input  logic            r0,
   input  logic            batch_start,
   input  logic [CW-1:0]   batch_size,
   pred_error_acc_if.slave pin,
   output logic            busy,
   output logic [CW-1:0]   count,
   output logic [AW-1:0]   sum_err,
   output logic [PW-1:0]   mae,
   output logic            mae_valid
`ifdef MAX_ERR_EN
   ,
   output logic [PW-1:0]   max_err
`endif
);
   state_t        state, state_nx;
   logic [CW-1:0] n;
   logic [PW-1:0] err, div_quo;
   logic          take, div_start, div_busy, div_done;
   assign err = PW'(abs_diff(MAXW'(pin.predict), MAXW'(pin.target)));
   // a coincident batch_start wins over the sample
   assign take = state == ACC && pin.pred_valid && !batch_start;
   // kick the divider once, on the first DIV cycle, when sum_err is final
   assign div_start = state == DIV && !div_busy && !div_done;
   always_ff @(posedge clk or negedge r0)
      if (!r0) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = batch_start ? ACC :
                 (take && count == n - CW'(1)) ? DIV :
                 (state == DIV && div_done) ? DONE :
                 (state == DONE) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge r0)
      if (!r0) begin
         n <= CW'(1);
         count <= '0;
         sum_err <= '0;
         mae <= '0;
         mae_valid <= 1'b0;
         busy <= 1'b0;
      end else begin
         mae_valid <= 1'b0;
         if (batch_start) begin
            n <= (batch_size == '0) ? CW'(1) : batch_size;
            count <= '0;
            sum_err <= '0;
            busy <= 1'b1;
         end else begin
            if (take) begin
               count <= count + CW'(1);
               sum_err <= sum_err + AW'(err);
            end
            if (state == DIV && div_done) begin
               mae <= div_quo;
               mae_valid <= 1'b1;
               busy <= 1'b0;
            end
         end
      end
`ifdef MAX_ERR_EN
   always_ff @(posedge clk or negedge r0)
      if (!r0) max_err <= '0;
      else if (batch_start) max_err <= '0;
      else if (take && err > max_err) max_err <= err;
`endif
   seq_divider #(
      .DW(AW),
      .VW(CW),
      .QW(PW)
   ) u_div (
      .clk(clk),
      .r0(r0),
      .clear(batch_start),
      .start(div_start),
      .dividend(sum_err),
      .divisor(n),
      .quotient(div_quo),
      .busy(div_busy),
      .done(div_done)
   );
endmodule

// File: tb/tb_pred_error_acc.sv
// tb_pred_error_acc: directed and random batches checked every cycle against a batch-level model.
module tb_pred_error_acc;
   localparam int PW = 32;
   localparam int CW = 8;
   localparam int AW = PW + CW;
   logic          clk = 1'b0;
   logic          r0 = 1'b0;
   logic          batch_start = 1'b0;
   logic [CW-1:0] batch_size = '0;
   logic          busy, mae_valid;
   logic [CW-1:0] count;
   logic [AW-1:0] sum_err;
   logic [PW-1:0] mae;
`ifdef MAX_ERR_EN
   logic [PW-1:0] max_err;
`endif
   pred_error_acc_if #(.PW(PW)) bus();
   pred_error_acc #(
      .PW(PW),
      .CW(CW),
      .AW(AW)
   ) dut (
      .clk(clk),
      .r0(r0),
      .batch_start(batch_start),
      .batch_size(batch_size),
      .pin(bus),
      .busy(busy),
      .count(count),
      .sum_err(sum_err),
      .mae(mae),
      .mae_valid(mae_valid)
`ifdef MAX_ERR_EN
      ,
      .max_err(max_err)
`endif
   );
   always #5 clk = ~clk;
   // model: the accepted errors of the open batch, plus when the result is due
   int     checks = 0;
   int     errors = 0;
   longint errs[$];
   int     m_n = 1;
   int     now = 0;
   int     m_due = -1;
   bit     m_busy = 1'b0;
   bit     m_open = 1'b0;
   bit     m_valid = 1'b0;
   longint m_mae = 0;
   function automatic longint total();
      longint s = 0;
      foreach (errs[i]) s += errs[i];
      return s;
   endfunction
   function automatic longint peak();
      longint m = 0;
      foreach (errs[i]) if (errs[i] > m) m = errs[i];
      return m;
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic check_all(input string tag);
      chk({tag, ".busy"}, 64'(busy), 64'(m_busy));
      chk({tag, ".count"}, 64'(count), 64'(errs.size()));
      chk({tag, ".sum_err"}, 64'(sum_err), total());
      chk({tag, ".mae_valid"}, 64'(mae_valid), 64'(m_valid));
      chk({tag, ".mae"}, 64'(mae), m_mae);
`ifdef MAX_ERR_EN
      chk({tag, ".max_err"}, 64'(max_err), peak());
`endif
   endtask
   task automatic model_reset();
      errs.delete();
      m_busy = 1'b0;
      m_open = 1'b0;
      m_valid = 1'b0;
      m_due = -1;
      m_mae = 0;
   endtask
   // drive one cycle, advance the model by the same clock edge, compare at the falling edge
   task automatic cyc(input string tag, input bit bs, input int bsz, input bit pv, input longint p, input longint t);
      batch_start = bs;
      batch_size = CW'(bsz);
      bus.pred_valid = pv;
      bus.predict = PW'(p);
      bus.target = PW'(t);
      @(negedge clk);
      now++;
      m_valid = 1'b0;
      if (bs) begin
         m_n = (bsz == 0) ? 1 : bsz;
         errs.delete();
         m_busy = 1'b1;
         m_open = 1'b1;
         m_due = -1;
      end else if (pv && m_open) begin
         errs.push_back(p >= t ? p - t : t - p);
         if (errs.size() == m_n) begin
            m_open = 1'b0;
            m_due = now + AW + 1;
         end
      end
      if (now == m_due) begin
         m_mae = total() / m_n;
         m_busy = 1'b0;
         m_valid = 1'b1;
         m_due = -1;
      end
      check_all(tag);
   endtask
   task automatic idle(input string tag, input int k);
      for (int i = 0; i < k; i++) cyc(tag, 1'b0, 0, 1'b0, 0, 0);
   endtask
   initial begin
      bus.pred_valid = 1'b0;
      bus.predict = '0;
      bus.target = '0;
      @(negedge clk);
      check_all("reset");
      r0 = 1'b1;
      // single exact sample; result must pulse exactly AW+2 cycles after the sample
      cyc("single", 1'b1, 1, 1'b0, 0, 0);
      cyc("single", 1'b0, 0, 1'b1, 1260000, 1260000);
      idle("single", AW + 3);
      chk("single_mae", 64'(mae), 0);
      // over- and under-estimate
      cyc("mix", 1'b1, 2, 1'b0, 0, 0);
      cyc("mix", 1'b0, 0, 1'b1, 1260000, 1250000);
      cyc("mix", 1'b0, 0, 1'b1, 510000, 530000);
      idle("mix", AW + 3);
      chk("mix_sum", 64'(sum_err), 30000);
      chk("mix_mae", 64'(mae), 15000);
      // batch_size 0 behaves as 1
      cyc("size0", 1'b1, 0, 1'b0, 0, 0);
      cyc("size0", 1'b0, 0, 1'b1, 1000, 1777);
      idle("size0", AW + 3);
      chk("size0_mae", 64'(mae), 777);
      // truncating division
      cyc("trunc", 1'b1, 3, 1'b0, 0, 0);
      cyc("trunc", 1'b0, 0, 1'b1, 5, 4);
      idle("trunc", 2);
      cyc("trunc", 1'b0, 0, 1'b1, 4, 5);
      cyc("trunc", 1'b0, 0, 1'b1, 10, 12);
      idle("trunc", AW + 3);
      chk("trunc_sum", 64'(sum_err), 4);
      chk("trunc_mae", 64'(mae), 1);
      // dropped samples: in IDLE, coincident with batch_start, after count reached n
      cyc("drop_idle", 1'b0, 0, 1'b1, 100, 0);
      cyc("drop_bs", 1'b1, 1, 1'b1, 999, 0);
      cyc("drop", 1'b0, 0, 1'b1, 7, 0);
      for (int i = 0; i < 4; i++) cyc("drop_full", 1'b0, 0, 1'b1, 500, 0);
      idle("drop", AW + 3);
      chk("drop_mae", 64'(mae), 7);
      // abort while dividing
      cyc("abort", 1'b1, 2, 1'b0, 0, 0);
      cyc("abort", 1'b0, 0, 1'b1, 50, 0);
      cyc("abort", 1'b0, 0, 1'b1, 70, 0);
      idle("abort_div", 10);
      cyc("abort", 1'b1, 4, 1'b0, 0, 0);
      idle("abort_wait", AW + 3);
      chk("abort_mae", 64'(mae), 7);
      for (int i = 0; i < 4; i++) cyc("abort_new", 1'b0, 0, 1'b1, 0, 40 * (i + 1));
      idle("abort_new", AW + 3);
      // asynchronous reset between edges in the middle of accumulation
      cyc("arst", 1'b1, 3, 1'b0, 0, 0);
      cyc("arst", 1'b0, 0, 1'b1, 30000, 20000);
      cyc("arst", 1'b0, 0, 1'b1, 0, 20000);
      r0 = 1'b0;
      #1;
      model_reset();
      check_all("arst_async");
      cyc("arst_low", 1'b0, 0, 1'b0, 0, 0);
      r0 = 1'b1;
      cyc("arst_after", 1'b0, 0, 1'b1, 5, 0);
      // random batches with gaps, stray samples and occasional size 0
      for (int b = 0; b < 8; b++) begin
         cyc("rand", 1'b1, $urandom_range(0, 6), 1'b0, 0, 0);
         for (int g = 0; g < 60 && m_open; g++)
            cyc("rand", 1'b0, 0, $urandom_range(0, 3) != 0, longint'($urandom), longint'($urandom));
         for (int g = 0; g < AW + 3; g++)
            cyc("rand_tail", 1'b0, 0, $urandom_range(0, 1) == 1, longint'($urandom), longint'($urandom));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
